// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX serialiser and the board RX path.
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - frame constants: data width and idle line level
//   - clks_per_bit(): divider ratio from system clock and line rate
// No ports (package).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Integer divide; the caller must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_ser_if.sv
// Byte handshake between an upstream producer and uart_tx_ser.
//   i_tx_byte   byte to send, sampled on handshake
//   i_tx_valid  producer has a byte
//   o_tx_ready  serialiser can accept a byte this cycle
// Valid/ready: a byte transfers on a rising clock edge where i_tx_valid and
// o_tx_ready are both high; the producer may change i_tx_byte freely otherwise.
// Modports: master = producer side, slave = serialiser side.
interface uart_tx_ser_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] i_tx_byte;
  logic                      i_tx_valid;
  logic                      o_tx_ready;

  modport master (output i_tx_byte, output i_tx_valid, input o_tx_ready);
  modport slave  (input i_tx_byte, input i_tx_valid, output o_tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, emitting a one-cycle
// tick on the last count of every bit period.
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset (count to 0)
//   i_clr    synchronous clear, aligns the bit period to a new frame
//   o_tick   high on the final cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmitter: one byte per frame, LSB first, 8N1/8N2 with optional parity.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (even parity, or odd when PARITY_ODD=1).
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   tx_if        byte handshake (slave side: i_tx_byte, i_tx_valid, o_tx_ready)
//   o_tx         serial line, idle high, registered
//   o_busy       frame in progress (drops on the final cycle of the last stop bit)
//   o_tx_done    one-cycle pulse on the final cycle of the last stop bit
//   o_dbg_state  current FSM state (uart_pkg ST_* encoding)
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  uart_tx_ser_if.slave tx_if,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_tx_done,
  output logic [2:0]   o_dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [2:0]                state_q, state_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      tick, last, ready, hs;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (hs),
    .o_tick  (tick)
  );

  // Final cycle of the frame: ready reopens here so a waiting byte starts
  // its start bit on the very next cycle.
  assign last  = (state_q == ST_STOP) && tick && (bit_q == LAST_STOP);
  assign ready = (state_q == ST_IDLE) || last;
  assign hs    = tx_if.i_tx_valid && ready;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (hs) begin
      state_d = ST_START;
      bit_d   = '0;
      shift_d = tx_if.i_tx_byte;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      // Parity is taken from the whole byte now, since the shift reg is consumed.
      par_d   = (PARITY_ODD != 0) ? ~^tx_if.i_tx_byte : ^tx_if.i_tx_byte;
`endif
    end else if (tick) begin
      case (state_q)
        ST_IDLE: ;
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
        ST_DATA: begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = UART_IDLE_LEVEL;
        end
`endif
        ST_STOP: begin
          tx_d = UART_IDLE_LEVEL;
          if (last) state_d = ST_IDLE;
          else      bit_d   = bit_q + 3'd1;
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = UART_IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_if.o_tx_ready = ready;
  assign o_tx             = tx_q;
  assign o_busy           = (state_q != ST_IDLE) && !last;
  assign o_tx_done        = last;
  assign o_dbg_state      = state_q;

endmodule
